// File: rtl/fetch_pkg.sv
// Shared widths, counter sizing and the queue entry type for the fetch front-end.
package fetch_pkg;

  localparam int ADDR_W_DEF  = 24;
  localparam int INSTR_W_DEF = 24;
  localparam int DEPTH_DEF   = 4;

  // Occupancy/credit counters must hold the value DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int CNT_W_DEF = cnt_w(DEPTH_DEF);

  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [ADDR_W_DEF-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Redirect, instruction-memory and decode-side signals of the fetch front-end.
interface fetch_queue_unit_if import fetch_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
);
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic [ADDR_W-1:0]  out_next_pc;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, out_next_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
    input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, out_next_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with a registered head (dout/vld), flush, and push+pop when full.
module fetch_fifo import fetch_pkg::*; #(
  parameter int             W        = 8,
  parameter int             DEPTH    = 4,
  parameter logic [W-1:0]   RST_DOUT = '0,
  localparam int            CW       = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          vld,
  output logic [CW-1:0] cnt
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic [CW-1:0] cnt_pop, cnt_nxt;
  logic          empty, full, pop_ok, push_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_nxt  = rd_ptr + PW'(pop_ok);
  assign cnt_pop = cnt - CW'(pop_ok);
  assign cnt_nxt = cnt_pop + CW'(push_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      vld    <= 1'b0;
      dout   <= RST_DOUT;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      vld    <= 1'b0;
    end else begin
      rd_ptr <= rd_nxt;
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      cnt    <= cnt_nxt;
      vld    <= (cnt_nxt != '0);
      // Head register: bypass the incoming word when the queue drains to empty this cycle.
      if (cnt_pop == '0) begin
        if (push_ok) dout <= din;
      end else begin
        dout <= mem[rd_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst && !flush) mem[wr_ptr] <= din;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop_ok));

endmodule

// File: rtl/fetch_queue_unit.sv
// Decoupled fetch: PC generator, credit-limited imem requests, drop counter for redirects, prefetch FIFO.
module fetch_queue_unit import fetch_pkg::*; #(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter int                DEPTH    = DEPTH_DEF,
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(1),
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                 CLK,
  input logic                 rst,
  fetch_queue_unit_if.master  bus
);
  localparam int          CW      = cnt_w(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  next_pc;
  } ent_t;

  localparam ent_t RST_ENT = '{instr: '0, pc: RESET_PC, next_pc: RESET_PC + PC_STEP};

  logic [ADDR_W-1:0] fetch_pc, rsp_pc;
  logic [CW-1:0]     inflight, drop, count;
  logic [CW:0]       used;
  logic              req_fire, rsp_drop, push, pop, vld;
  ent_t              din, dout;

  // Credits cover both buffered entries and outstanding requests, so the queue cannot overflow.
  assign used               = {1'b0, count} + {1'b0, inflight};
  assign bus.imem_req_valid = !rst && !bus.redirect_valid && (used < DEPTH_C);
  assign bus.imem_req_addr  = fetch_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign rsp_drop = (drop != '0);
  assign push     = bus.imem_rsp_valid && !rsp_drop && !bus.redirect_valid;
  assign pop      = bus.out_ready && !bus.redirect_valid;
  assign din      = '{instr: bus.imem_rsp_data, pc: rsp_pc, next_pc: rsp_pc + PC_STEP};

  always_ff @(posedge CLK) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else if (bus.redirect_valid) begin
      // Everything still outstanding belongs to the old path; a same-cycle response is simply lost.
      fetch_pc <= bus.redirect_pc;
      rsp_pc   <= bus.redirect_pc;
      inflight <= inflight - CW'(bus.imem_rsp_valid);
      drop     <= inflight - CW'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
      inflight <= inflight + CW'(req_fire) - CW'(bus.imem_rsp_valid);
      if (bus.imem_rsp_valid) begin
        if (rsp_drop) drop   <= drop - CW'(1);
        else          rsp_pc <= rsp_pc + PC_STEP;
      end
    end
  end

  fetch_fifo #(
    .W        ($bits(ent_t)),
    .DEPTH    (DEPTH),
    .RST_DOUT (RST_ENT)
  ) u_fifo (
    .clk   (CLK),
    .rst   (rst),
    .flush (bus.redirect_valid),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (dout),
    .vld   (vld),
    .cnt   (count)
  );

  assign bus.out_valid   = vld;
  assign bus.out_instr   = dout.instr;
  assign bus.out_pc      = dout.pc;
  assign bus.out_next_pc = dout.next_pc;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Random + directed bench: in-order memory model, epoch-tagged reference queue, decoupled scoreboard monitor.
module tb_fetch_queue_unit;
  import fetch_pkg::*;

  localparam int            AW     = 24;
  localparam int            IW     = 24;
  localparam int            DEPTH  = 4;
  localparam logic [AW-1:0] RST_PC = 24'h000010;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  always #5 CLK = ~CLK;

  fetch_queue_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  fetch_queue_unit #(
    .ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .PC_STEP(24'd1), .RESET_PC(RST_PC)
  ) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory contents: a fixed scramble of the address.
  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    logic [AW-1:0] m;
    m = a * 24'h009E37;
    return m ^ 24'hA5C3F1;
  endfunction

  // ---------------- in-order instruction memory ----------------
  typedef struct { logic [AW-1:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;

  always @(negedge CLK) begin
    int d;
    if (rst) mq.delete();
    else if (bus.imem_req_valid && bus.imem_req_ready) begin
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq.push_back('{bus.imem_req_addr, d});
    end
  end

  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(posedge CLK);
      cyc = cyc + 1;
      #1;
      if (mq.size() != 0 && mq[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
      end
    end
  end

  // ---------------- reference model + scoreboard monitor ----------------
  typedef struct { logic [AW-1:0] pc; int ep; } preq_t;
  preq_t         pend[$];
  fetch_entry_t  sb[$];
  logic [AW-1:0] exp_fetch = RST_PC;
  int            epoch = 0, req_cnt = 0, pop_cnt = 0;
  bit            prev_rst = 1'b1;

  always @(negedge CLK) begin
    preq_t p;
    if (rst) begin
      chk("req_valid_in_rst", bus.imem_req_valid, 0);
      pend.delete();
      sb.delete();
      exp_fetch = RST_PC;
    end else begin
      if (prev_rst) begin
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_pc", bus.out_pc, RST_PC);
        chk("rst_out_next_pc", bus.out_next_pc, RST_PC + 24'd1);
        chk("rst_out_instr", bus.out_instr, 0);
        if (!bus.redirect_valid) chk("first_req_after_rst", bus.imem_req_valid, 1);
      end
      chk("out_valid", bus.out_valid, sb.size() != 0);
      if (bus.out_valid && sb.size() != 0) begin
        chk("out_pc", bus.out_pc, sb[0].pc);
        chk("out_instr", bus.out_instr, sb[0].instr);
        chk("out_next_pc", bus.out_next_pc, AW'(sb[0].pc + 24'd1));
      end
      chk("req_valid", bus.imem_req_valid,
          !bus.redirect_valid && (sb.size() + pend.size() < DEPTH));

      if (bus.redirect_valid) begin
        if (bus.imem_rsp_valid && pend.size() != 0) void'(pend.pop_front());
        sb.delete();
        epoch++;
        exp_fetch = bus.redirect_pc;
      end else begin
        if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
          void'(sb.pop_front());
          pop_cnt++;
        end
        if (bus.imem_rsp_valid) begin
          chk("rsp_has_req", pend.size() != 0, 1);
          if (pend.size() != 0) begin
            p = pend.pop_front();
            if (p.ep == epoch) sb.push_back('{instr: mem_word(p.pc), pc: p.pc});
          end
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          chk("req_addr", bus.imem_req_addr, exp_fetch);
          pend.push_back('{exp_fetch, epoch});
          exp_fetch = exp_fetch + 24'd1;
          req_cnt++;
        end
      end
    end
    prev_rst = rst;
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic redirect(input logic [AW-1:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    step(1);
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    int r0, p0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b1;
    bus.out_ready      = 1'b1;
    rst = 1'b1;
    step(3);

    // Streaming at one instruction per cycle with a 1-cycle memory.
    rst = 1'b0;
    step(5);
    p0 = pop_cnt;
    step(20);
    chk("stream_rate", pop_cnt - p0, 20);

    // Decode stalled: issue stops at DEPTH credits, then drains without gaps.
    bus.out_ready = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    r0 = req_cnt;
    step(10);
    chk("hold_reqs", req_cnt - r0, DEPTH);
    chk("hold_valid", bus.out_valid, 1);
    chk("hold_pc", bus.out_pc, RST_PC);
    bus.out_ready = 1'b1;
    p0 = pop_cnt;
    step(10);
    chk("release_pops", pop_cnt - p0, 10);

    // 3-cycle memory with requests in flight, then redirect.
    lat_min = 3; lat_max = 3;
    step(10);
    redirect(24'h000200);
    step(15);

    // Redirect while a response and a pop are both active.
    lat_min = 1; lat_max = 1;
    step(10);
    redirect(24'h000300);
    chk("redir_flush_valid", bus.out_valid, 0);
    step(10);

    // PC wrap.
    redirect(24'hFFFFFF);
    step(10);

    // Reset with entries queued and requests still outstanding.
    lat_min = 4; lat_max = 4;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(6);
    rst = 1'b1;
    step(1);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_pc", bus.out_pc, RST_PC);
    step(1);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    step(10);

    // Randomized traffic.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      bus.imem_req_ready = ($urandom % 4) != 0;
      bus.out_ready      = ($urandom % 10) < 7;
      bus.redirect_valid = ($urandom % 32) == 0;
      bus.redirect_pc    = (($urandom % 4) == 0) ? AW'(24'hFFFFFE + ($urandom % 3)) : AW'($urandom);
      rst                = ($urandom % 600) == 0;
      step(1);
    end
    bus.redirect_valid = 1'b0;
    rst = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.out_ready = 1'b1;
    step(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
